// File: rtl/reg_file_8x8.sv
// Eight-entry register file with one-hot write select, two registered read ports,
// write-first forwarding, a sticky malformed-select flag and a committed-write counter.
module reg_file_8x8 #(
  parameter int DATA_W  = 8,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        we_onehot,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        rd_sel_a,
  input  logic [2:0]        rd_sel_b,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              err_multi,
  output logic [7:0]        wr_cnt
);

  logic [7:0][DATA_W-1:0] regs;
  logic                   one_hot;
  logic                   commit;
  logic                   malformed;
  logic [2:0]             wr_idx;
  logic [DATA_W-1:0]      wr_val;

  logic [DATA_W-1:0]      rd_a_q, rd_a_d;
  logic [DATA_W-1:0]      rd_b_q, rd_b_d;
  logic                   err_q, err_d;
  logic [7:0]             cnt_q, cnt_d;

  // Exactly-one-bit test: nonzero and clearing the lowest set bit leaves nothing.
  always_comb begin
    one_hot   = (we_onehot != 8'd0) && ((we_onehot & (we_onehot - 8'd1)) == 8'd0);
    commit    = wr_en && one_hot;
    malformed = wr_en && (we_onehot != 8'd0) && !one_hot;
  end

  always_comb begin
    wr_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (we_onehot[i]) wr_idx = 3'(i);
    end
    wr_val = (R0_ZERO && (wr_idx == 3'd0)) ? '0 : wr_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_regs
      if (R0_ZERO && (gi == 0)) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] data_q;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            data_q <= '0;
          end else if (commit && we_onehot[gi]) begin
            data_q <= wr_data;
          end
        end
        assign regs[gi] = data_q;
      end
    end
  endgenerate

  // Write-first: a committed write to the selected index bypasses storage.
  always_comb begin
    rd_a_d = (commit && (wr_idx == rd_sel_a)) ? wr_val : regs[rd_sel_a];
    rd_b_d = (commit && (wr_idx == rd_sel_b)) ? wr_val : regs[rd_sel_b];
    err_d  = err_q;
    if (malformed) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
    cnt_d = cnt_q + {7'd0, commit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign err_multi = err_q;
  assign wr_cnt    = cnt_q;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8: writes, forwarding, malformed selects,
// register-0 behaviour, counter wrap and asynchronous reset.
module tb_reg_file_8x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] we_onehot;
  logic [7:0] wr_data;
  logic [2:0] rd_sel_a;
  logic [2:0] rd_sel_b;
  logic       clr_err;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       err_multi;
  logic [7:0] wr_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  reg_file_8x8 #(.DATA_W(8), .R0_ZERO(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .we_onehot (we_onehot),
    .wr_data   (wr_data),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .clr_err   (clr_err),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .err_multi (err_multi),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [7:0] data);
    wr_en     = 1'b1;
    we_onehot = 8'd1 << idx;
    wr_data   = data;
    tick();
    wr_en     = 1'b0;
    we_onehot = 8'd0;
    exp_cnt   = (exp_cnt + 1) % 256;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; we_onehot = 8'd0; wr_data = 8'd0;
    rd_sel_a = 3'd0; rd_sel_b = 3'd0; clr_err = 1'b0;
    #12;
    check("reset_rd_a", rd_data_a, 8'h00);
    check("reset_rd_b", rd_data_b, 8'h00);
    check("reset_err", err_multi, 1'b0);
    check("reset_cnt", wr_cnt, 8'h00);
    rst = 1'b0;
    tick();

    // Write 0xA5 to R3, then read it back on port A.
    do_write(3'd3, 8'hA5);
    rd_sel_a = 3'd3;
    tick();
    check("r3_read_a", rd_data_a, 8'hA5);
    check("cnt_after_r3", wr_cnt, 8'd1);
    $display("txn write R3=0xA5 read_a=0x%0h cnt=%0d", rd_data_a, wr_cnt);

    // Write 0x5C to R5 while port B selects R5 on the same edge.
    rd_sel_b = 3'd5;
    do_write(3'd5, 8'h5C);
    check("r5_forward_b", rd_data_b, 8'h5C);
    check("cnt_after_r5", wr_cnt, 8'd2);
    $display("txn write R5=0x5C forwarded read_b=0x%0h", rd_data_b);

    // Malformed select: nothing written, nothing forwarded, error set.
    rd_sel_a = 3'd3; rd_sel_b = 3'd4;
    wr_en = 1'b1; we_onehot = 8'h18; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0; we_onehot = 8'd0;
    check("malformed_r3", rd_data_a, 8'hA5);
    check("malformed_r4", rd_data_b, 8'h00);
    check("malformed_err", err_multi, 1'b1);
    check("malformed_cnt", wr_cnt, 8'd2);
    tick();
    check("err_sticky", err_multi, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("err_cleared", err_multi, 1'b0);
    $display("txn malformed we=0x18 err set then cleared");

    // Set wins when clear and a malformed write coincide.
    wr_en = 1'b1; we_onehot = 8'h81; clr_err = 1'b1;
    tick();
    wr_en = 1'b0; we_onehot = 8'd0; clr_err = 1'b0;
    check("set_wins", err_multi, 1'b1);
    // wr_en with empty select: no write, error and count unchanged.
    wr_en = 1'b1; we_onehot = 8'h00; wr_data = 8'h33;
    tick();
    wr_en = 1'b0;
    check("empty_sel_err", err_multi, 1'b1);
    check("empty_sel_cnt", wr_cnt, 8'd2);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    // wr_en low with a malformed select raises no error.
    we_onehot = 8'hFF; wr_data = 8'hEE; rd_sel_a = 3'd7;
    tick();
    we_onehot = 8'd0;
    check("wr_en_low_err", err_multi, 1'b0);
    check("wr_en_low_r7", rd_data_a, 8'h00);
    $display("txn set-wins / empty select / wr_en low checked");

    // Register 0 stays zero but the write is counted.
    rd_sel_a = 3'd0;
    do_write(3'd0, 8'h77);
    check("r0_forward_zero", rd_data_a, 8'h00);
    check("r0_cnt", wr_cnt, 8'd3);
    tick();
    check("r0_read_zero", rd_data_a, 8'h00);
    $display("txn write R0=0x77 read=0x%0h cnt=%0d", rd_data_a, wr_cnt);

    // Identical selects on both ports.
    rd_sel_a = 3'd5; rd_sel_b = 3'd5;
    tick();
    check("same_sel_a", rd_data_a, 8'h5C);
    check("same_sel_b", rd_data_b, 8'h5C);

    // Counter wrap: run up to 255, then one more write returns to 0.
    for (int i = 0; exp_cnt != 255; i++) begin
      do_write(3'd7, 8'(i));
    end
    check("cnt_255", wr_cnt, 8'hFF);
    do_write(3'd6, 8'h42);
    check("cnt_wrap", wr_cnt, 8'h00);
    $display("txn counter wrap cnt=0x%0h", wr_cnt);

    // Load R1..R7, then assert reset between clock edges.
    for (int i = 1; i < 8; i++) begin
      do_write(3'(i), 8'(8'h11 * i));
    end
    rd_sel_a = 3'd7; rd_sel_b = 3'd1;
    tick();
    check("preload_r7", rd_data_a, 8'h77);
    check("preload_r1", rd_data_b, 8'h11);
    check("preload_cnt", wr_cnt, 8'd7);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_a", rd_data_a, 8'h00);
    check("async_rst_b", rd_data_b, 8'h00);
    check("async_rst_cnt", wr_cnt, 8'h00);
    // Writes during reset are ignored.
    wr_en = 1'b1; we_onehot = 8'h04; wr_data = 8'h99;
    tick();
    check("rst_hold_cnt", wr_cnt, 8'h00);
    wr_en = 1'b0; we_onehot = 8'd0;
    rst = 1'b0;
    $display("txn async reset cleared outputs");
    for (int i = 1; i < 8; i++) begin
      rd_sel_a = 3'(i); rd_sel_b = 3'(i);
      tick();
      check($sformatf("post_rst_a_r%0d", i), rd_data_a, 8'h00);
      check($sformatf("post_rst_b_r%0d", i), rd_data_b, 8'h00);
    end
    $display("txn post-reset reads of R1..R7 done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_8x8.md
REG_FILE_8X8 -- requirements
Module: reg_file_8x8

Interface
REQ-001 Parameter: DATA_W, default 8, width of each register and each data port.
REQ-002 Parameter: R0_ZERO, default 1, when 1 register 0 is hardwired to zero.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: wr_en  input  1  global write strobe.
REQ-006 Port: we_onehot  input  8  one-hot register write select, produced by the upstream 3-to-8 destination decoder; bit i selects register i.
REQ-007 Port: wr_data  input  DATA_W  write data.
REQ-008 Port: rd_sel_a  input  3  read port A register index.
REQ-009 Port: rd_sel_b  input  3  read port B register index.
REQ-010 Port: clr_err  input  1  synchronous clear of the error flag.
REQ-011 Port: rd_data_a  output  DATA_W  registered read data, port A.
REQ-012 Port: rd_data_b  output  DATA_W  registered read data, port B.
REQ-013 Port: err_multi  output  1  sticky flag: malformed write select detected.
REQ-014 Port: wr_cnt  output  8  count of committed writes, wraps modulo 256.

Function
REQ-015 Storage SHALL be 8 registers of DATA_W bits, indices 0..7.
REQ-016 Write commit SHALL occur on a rising edge when wr_en=1 and we_onehot has exactly one bit set; the selected register takes wr_data.
REQ-017 wr_en=1 with we_onehot=0 SHALL write nothing, leave err_multi unchanged, and leave wr_cnt unchanged.
REQ-018 wr_en=1 with two or more we_onehot bits set SHALL write nothing and set err_multi on that edge.
REQ-019 wr_en=0 SHALL write nothing and raise no error, regardless of we_onehot.
REQ-020 err_multi SHALL remain 1 until clr_err=1 at a rising edge; if clr_err and a new malformed write coincide, set wins (err_multi stays 1).
REQ-021 wr_cnt SHALL increment by 1 per committed write (REQ-016), including writes to register 0 when R0_ZERO=1; 255+1 wraps to 0.
REQ-022 When R0_ZERO=1, register 0 SHALL always read 0; a write to it is discarded but still counted.
REQ-023 Reads SHALL have 1-cycle latency: rd_data_x at edge N+1 reflects rd_sel_x sampled at edge N.
REQ-024 Read-during-write SHALL be write-first: if a committed write targets the same index as rd_sel_x on the same edge, rd_data_x takes wr_data (0 if the index is 0 and R0_ZERO=1).
REQ-025 Both read ports SHALL operate independently; identical selects return identical data.
REQ-026 Malformed writes (REQ-018) SHALL NOT be forwarded; reads return stored contents.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for clk, clear all 8 registers, rd_data_a, rd_data_b, err_multi and wr_cnt to 0.
REQ-028 While rst=1, no write, count or error update SHALL occur.
REQ-029 On rst deassertion, the first rising edge SHALL operate normally.
REQ-030 rst asserted between clock edges during a write sequence SHALL abort it; no partial write survives.

Verification
REQ-031 Reset, then write 0xA5 to R3 (we_onehot=0x08), then read with rd_sel_a=3 -> rd_data_a=0xA5 one cycle after select, wr_cnt=1.
REQ-032 Write 0x5C to R5 while rd_sel_b=5 on the same edge -> rd_data_b=0x5C at the next cycle (forwarded).
REQ-033 wr_en=1, we_onehot=0x18, wr_data=0xFF -> R3 and R4 unchanged, err_multi=1, wr_cnt unchanged; clr_err=1 for one cycle -> err_multi=0.
REQ-034 Write 0x77 to R0 with R0_ZERO=1 -> rd_data_a=0x00 for rd_sel_a=0, wr_cnt incremented.
REQ-035 Perform 256 committed writes -> wr_cnt returns to 0x00.
REQ-036 Load R1..R7 with nonzero values, assert rst between clock edges -> all outputs 0 immediately; subsequent reads of R1..R7 return 0.
